truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Self-contained sequencer that exhaustively exercises a combinational N_IN-input, 1-output function block in hardware.
//  Drives every input vector 0..2^N_IN-1 in ascending order and waits SETTLE cycles for each one.
//  Samples f, compares it with an expected truth table and reports pass/fail, mismatch count and first failing vector.
//  Sits beside the function block on the lab board; vec drives the block's a,b,c,d pins and f returns.
// PARAMETERS
//  N_IN    4  number of function inputs; sweep length is 2^N_IN vectors
//  SETTLE  2  cycles vec is held before f is sampled; legal range 1..15
// PORTS
//  clk             in   1          single system clock, rising edge
//  rst             in   1          asynchronous, active-high reset
//  start           in   1          begin a sweep; sampled only in IDLE or DONE
//  abort           in   1          cancel a running sweep
//  expected        in   2^N_IN     golden table; bit i = required f for vec==i
//  f               in   1          output of the function block under control
//  vec             out  N_IN       input vector to block; {a,b,c,d} = vec[3:0] for N_IN=4
//  busy            out  1          sweep in progress (states SETTLE/SAMPLE)
//  done            out  1          sweep completed; held until next start
//  pass            out  1          valid with done: 1 = zero mismatches
//  err_cnt         out  N_IN+1     number of mismatching vectors (0..2^N_IN)
//  first_fail      out  N_IN       lowest vector index that mismatched
//  first_fail_vld  out  1          first_fail holds a valid index
//  captured        out  2^N_IN     observed table; bit i = f sampled at vec==i
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE, applied immediately on rst rise; reset mid-sweep discards all results.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  IDLE/DONE + start (abort=0), at the clock edge:
//   - vec<=0, err_cnt<=0, captured<=0, first_fail<=0, first_fail_vld<=0, done<=0, pass<=0
//   - settle counter<=0, state->SETTLE
//  SETTLE: vec held; counter increments each cycle; after SETTLE cycles in this state -> SAMPLE.
//  SAMPLE (one cycle), at its edge:
//   - captured[vec]<=f
//   - if f!=expected[vec]: err_cnt++; if !first_fail_vld, first_fail<=vec and first_fail_vld<=1
//   - if vec==2^N_IN-1: ->DONE with done<=1 and pass<=(no mismatch incl. this vector)
//   - else vec++, counter<=0, ->SETTLE
//  Latency: done rises (SETTLE+1)*2^N_IN edges after the start edge; 48 for the defaults.
//  busy = state in {SETTLE,SAMPLE}, combinational from state.
//  start while busy: ignored.
//  abort while busy: next edge ->IDLE, vec<=0, done<=0, pass<=0; err_cnt/captured keep partial values.
//  start and abort together in IDLE/DONE: abort wins; state->IDLE, results cleared, done<=0.
//  DONE: vec stays at 2^N_IN-1 and all results stay stable until start, abort or rst.
//  vec never wraps inside a sweep; err_cnt is sized so 2^N_IN mismatches cannot overflow.
//  expected is sampled live in SAMPLE and must be held stable for the whole sweep.
// STRUCTURE
//  Shared include tt_defs.vh: FSM state encodings (2-bit) and the SETTLE range-check macro.
//  One natural sub-module: tt_settle_timer (load/count/expire, width 4), instantiated once.
//  Vector counter, result registers and FSM are local to this module.
// TESTING
//  Bench models f=(a&b)|(c&~d), whose table is 16'hF444; defaults N_IN=4, SETTLE=2.
//  1 expected=16'hF444, start pulse -> done 48 cycles later, pass=1, err_cnt=0, captured=16'hF444, first_fail_vld=0.
//  2 expected=16'hF445 -> pass=0, err_cnt=1, first_fail=0, first_fail_vld=1, captured=16'hF444.
//  3 expected=16'h0BBB (all bits wrong) -> err_cnt=16 (5'b10000), first_fail=0, pass=0.
//  4 f stuck at 0, expected=16'hF444 -> captured=16'h0000, err_cnt=7, first_fail=2.
//  5 abort 10 cycles after start -> busy=0 and vec=0 next edge, done=0; a re-start then completes as in test 1.
//  6 rst raised mid-sweep between edges -> all outputs 0 at once; start pulses while busy -> vec sequence unchanged.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding, timer width
// and the settle-count range guard.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int TIMER_W = 4;

  // Keeps the settle count inside what a TIMER_W-bit timer can reach (1..15).
  function automatic int settle_clamp(input int s);
    if (s < 1) return 1;
    if (s > 15) return 15;
    return s;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-delay timer: cleared while idle, counts while enabled, and flags the
// last cycle of a LIMIT-cycle hold window.
module tt_settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + TIMER_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of an N_IN-input function block in ascending order,
// samples its output after a settle delay and scores it against a golden table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 first_fail_vld,
  output logic [2**N_IN-1:0]   captured
);

  localparam int              DEPTH      = 2**N_IN;
  localparam int              SETTLE_EFF = settle_clamp(SETTLE);
  localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};

  state_e            state_q;
  logic [N_IN-1:0]   vec_q;
  logic [N_IN:0]     err_cnt_q;
  logic [N_IN-1:0]   first_fail_q;
  logic              first_fail_vld_q;
  logic              done_q;
  logic              pass_q;
  logic [DEPTH-1:0]  captured_q, captured_d;

  logic              settle_done;
  logic              mismatch;
  logic              idle_or_done;
  logic              res_clear;
  logic              sample_en;
  logic [DEPTH-1:0]  hit;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign res_clear    = idle_or_done && (start || abort);
  assign sample_en    = (state_q == ST_SAMPLE) && !abort;
  assign mismatch     = f ^ expected[vec_q];

  tt_settle_timer #(
    .LIMIT(SETTLE_EFF)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q != ST_SETTLE),
    .en_i    (state_q == ST_SETTLE),
    .expire_o(settle_done)
  );

  // One-hot decode of the vector being sampled; only that bit of the observed table moves.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cap
    assign hit[gi]        = sample_en && (vec_q == N_IN'(gi));
    assign captured_d[gi] = res_clear ? 1'b0 : (hit[gi] ? f : captured_q[gi]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      vec_q            <= '0;
      err_cnt_q        <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      captured_q       <= '0;
    end else begin
      captured_q <= captured_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start || abort) begin
            vec_q            <= '0;
            err_cnt_q        <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            state_q          <= abort ? ST_IDLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (settle_done) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            if (mismatch) begin
              err_cnt_q <= err_cnt_q + (N_IN+1)'(1);
              if (!first_fail_vld_q) begin
                first_fail_q     <= vec_q;
                first_fail_vld_q <= 1'b1;
              end
            end
            // Last vector: pass must account for this final sample, not just the running count.
            if (vec_q == VEC_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_q == '0) && !mismatch;
            end else begin
              vec_q   <= vec_q + N_IN'(1);
              state_q <= ST_SETTLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign vec            = vec_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;
  assign captured       = captured_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: golden-table vectors, randomized tables scored by a
// popcount/lowest-bit reference, plus abort, reset and start-while-busy sequences.
module tb_truth_table_sweeper;

  localparam int SWEEP_EDGES = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        f;
  logic [3:0]  vec;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_cnt;
  logic [3:0]  first_fail;
  logic        first_fail_vld;
  logic [15:0] captured;

  // Table the emulated function block answers with; f follows vec combinationally.
  logic [15:0] dut_table;
  assign f = dut_table[vec];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .expected      (expected),
    .f             (f),
    .vec           (vec),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_fail    (first_fail),
    .first_fail_vld(first_fail_vld),
    .captured      (captured)
  );

  typedef struct {
    string       name;
    logic [15:0] tbl;
    logic [15:0] exp;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        ffv;
    logic [15:0] cap;
  } vec_t;

  typedef struct {
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        ffv;
    logic [15:0] cap;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: score an observed table against a golden table directly.
  task automatic ref_model(input logic [15:0] e, input logic [15:0] t, output res_t r);
    logic [15:0] diff;
    diff  = e ^ t;
    r.cap = t;
    r.err = '0;
    r.ffv = 1'b0;
    r.ff  = '0;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) begin
        r.err = r.err + 5'd1;
        if (!r.ffv) begin
          r.ff  = 4'(i);
          r.ffv = 1'b1;
        end
      end
    end
    r.pass = (diff == 16'h0000);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one sweep and returns the number of edges from the start edge to done.
  task automatic run_sweep(input logic [15:0] t, input logic [15:0] e, output int lat);
    dut_table = t;
    expected  = e;
    pulse_start();
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag, input res_t r, input int lat);
    check({tag, " latency"}, 32'(lat), 32'(SWEEP_EDGES));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " vec"}, 32'(vec), 32'hF);
    check({tag, " pass"}, 32'(pass), 32'(r.pass));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(r.err));
    check({tag, " first_fail"}, 32'(first_fail), 32'(r.ff));
    check({tag, " first_fail_vld"}, 32'(first_fail_vld), 32'(r.ffv));
    check({tag, " captured"}, 32'(captured), 32'(r.cap));
  endtask

  initial begin
    vec_t        tbl [4];
    res_t        r;
    int          lat;
    logic [15:0] e, t;

    tbl[0] = '{"golden",     16'hF444, 16'hF444, 1'b1, 5'd0,  4'd0, 1'b0, 16'hF444};
    tbl[1] = '{"one_bit",    16'hF444, 16'hF445, 1'b0, 5'd1,  4'd0, 1'b1, 16'hF444};
    tbl[2] = '{"all_wrong",  16'hF444, 16'h0BBB, 1'b0, 5'b10000, 4'd0, 1'b1, 16'hF444};
    tbl[3] = '{"stuck_zero", 16'h0000, 16'hF444, 1'b0, 5'd7,  4'd2, 1'b1, 16'h0000};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    expected = 16'h0000; dut_table = 16'hF444;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset vec", 32'(vec), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset captured", 32'(captured), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      r.pass = tbl[i].pass; r.err = tbl[i].err; r.ff = tbl[i].ff;
      r.ffv = tbl[i].ffv; r.cap = tbl[i].cap;
      run_sweep(tbl[i].tbl, tbl[i].exp, lat);
      check_results(tbl[i].name, r, lat);
      $display("vector %s: err_cnt=%0d first_fail=%0d pass=%0b captured=%h",
               tbl[i].name, err_cnt, first_fail, pass, captured);
    end

    // Results hold in DONE while idle
    repeat (5) @(posedge clk);
    #1;
    check("done hold", 32'(done), 32'd1);
    check("done hold err_cnt", 32'(err_cnt), 32'd7);

    // Abort at the 10th edge after start: vectors 0..2 already scored
    dut_table = 16'hF444;
    expected  = 16'h0BBB;
    pulse_start();
    repeat (9) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort vec", 32'(vec), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort err_cnt", 32'(err_cnt), 32'd3);
    check("abort captured", 32'(captured), 32'h0004);
    $display("abort: err_cnt=%0d captured=%h", err_cnt, captured);
    ref_model(16'hF444, 16'hF444, r);
    run_sweep(16'hF444, 16'hF444, lat);
    check_results("restart", r, lat);

    // start and abort together in DONE: abort wins and results clear
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk);
    #1;
    check("start+abort busy", 32'(busy), 32'd0);
    check("start+abort done", 32'(done), 32'd0);
    check("start+abort captured", 32'(captured), 32'd0);

    // Asynchronous reset between edges mid-sweep
    dut_table = 16'hF444;
    expected  = 16'h0BBB;
    pulse_start();
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst vec", 32'(vec), 32'd0);
    check("async rst err_cnt", 32'(err_cnt), 32'd0);
    check("async rst captured", 32'(captured), 32'd0);
    check("async rst first_fail_vld", 32'(first_fail_vld), 32'd0);
    $display("async reset: vec=%0d err_cnt=%0d busy=%0b", vec, err_cnt, busy);
    @(negedge clk);
    rst = 1'b0;

    // Random start pulses while busy must not disturb the vector sequence
    dut_table = 16'hF444;
    expected  = 16'hF444;
    pulse_start();
    for (int k = 1; k <= SWEEP_EDGES; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check($sformatf("noisy vec@%0d", k), 32'(vec), (k / 3 > 15) ? 32'd15 : 32'(k / 3));
      check($sformatf("noisy done@%0d", k), 32'(done), (k == SWEEP_EDGES) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    $display("noisy start sweep: done=%0b pass=%0b", done, pass);

    // Randomized tables scored by the reference model
    for (int it = 0; it < 20; it++) begin
      e = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       t = e;
        1:       t = e ^ (16'h1 << $urandom_range(0, 15));
        default: t = 16'($urandom);
      endcase
      ref_model(e, t, r);
      run_sweep(t, e, lat);
      check_results($sformatf("rand%0d", it), r, lat);
      $display("rand%0d: expected=%h table=%h err_cnt=%0d first_fail=%0d pass=%0b",
               it, e, t, err_cnt, first_fail, pass);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
